axi4_bresp_scheduler: RTL and testbench

AXI4_BRESP_SCHEDULER -- requirements
Module: axi4_bresp_scheduler

---
 rtl/axi4_bresp_scheduler.sv | 137 +++++++++++++
 tb/tb_axi4_bresp_scheduler.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_bresp_scheduler.sv
// rtl/axi4_bresp_scheduler.sv - age-ordered AXI4 write-response queue with in-order/OOO/QoS B-channel scheduling
module axi4_bresp_scheduler #(
    parameter int ID_WIDTH  = 4,
    parameter int DEPTH     = 8,
    parameter int QOS_WIDTH = 4,
    localparam int CW       = $clog2(DEPTH + 1),
    localparam int IW       = $clog2(DEPTH)
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [1:0]           resp_mode,
    input  logic [1:0]           qos_mode,
    input  logic                 push_valid,
    output logic                 push_ready,
    input  logic [ID_WIDTH-1:0]  push_id,
    input  logic [1:0]           push_resp,
    input  logic [QOS_WIDTH-1:0] push_qos,
    output logic                 bvalid,
    input  logic                 bready,
    output logic [ID_WIDTH-1:0]  bid,
    output logic [1:0]           bresp,
    output logic [CW-1:0]        occupancy
);

    // Slot 0 is the oldest entry; slots at or above count are don't-care.
    logic [ID_WIDTH-1:0]  q_id   [DEPTH];
    logic [1:0]           q_resp [DEPTH];
    logic [QOS_WIDTH-1:0] q_qos  [DEPTH];
    logic [CW-1:0]        count;

    logic [DEPTH-1:0]     eligible;
    logic [IW-1:0]        sel_idx;
    logic [IW-1:0]        wr_idx;
    logic                 found;
    logic                 better;
    logic [QOS_WIDTH-1:0] best_qos;
    logic [ID_WIDTH-1:0]  best_id;
    logic                 ooo_on;
    logic                 qos_on;
    logic                 do_load;
    logic                 do_push;

    assign ooo_on     = (resp_mode == 2'b10) || (resp_mode == 2'b11);
    assign qos_on     = (qos_mode == 2'b10) || (qos_mode == 2'b11);
    assign push_ready = (count < CW'(DEPTH));
    assign do_push    = push_valid && push_ready;
    assign do_load    = (count != '0) && (!bvalid || bready);
    assign wr_idx     = IW'(count - CW'(do_load));
    assign occupancy  = count;

    // Only the oldest entry of each ID may be issued, keeping same-ID responses in order.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < DEPTH; i++) begin
            eligible[i] = (CW'(i) < count);
            for (int j = 0; j < i; j++) begin
                if (q_id[j] == q_id[i]) begin
                    eligible[i] = 1'b0;
                end
            end
        end
    end

    // Eligible IDs are unique, so the lowest-ID tie-break is always decisive.
    always_comb begin
        sel_idx  = '0;
        found    = 1'b0;
        better   = 1'b0;
        best_qos = '0;
        best_id  = '0;
        if (ooo_on) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (eligible[i]) begin
                    if (!found) begin
                        better = 1'b1;
                    end else if (qos_on) begin
                        better = (q_qos[i] > best_qos) ||
                                 ((q_qos[i] == best_qos) && (q_id[i] < best_id));
                    end else begin
                        better = (q_id[i] < best_id);
                    end
                    if (better) begin
                        found    = 1'b1;
                        sel_idx  = IW'(i);
                        best_qos = q_qos[i];
                        best_id  = q_id[i];
                    end
                end
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            count  <= '0;
            bvalid <= 1'b0;
            bid    <= '0;
            bresp  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_id[i]   <= '0;
                q_resp[i] <= '0;
                q_qos[i]  <= '0;
            end
        end else begin
            if (do_load) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    if (IW'(i) >= sel_idx) begin
                        q_id[i]   <= q_id[i+1];
                        q_resp[i] <= q_resp[i+1];
                        q_qos[i]  <= q_qos[i+1];
                    end
                end
            end
            // Append lands after the collapse so it targets the post-removal tail.
            if (do_push) begin
                q_id[wr_idx]   <= push_id;
                q_resp[wr_idx] <= push_resp;
                q_qos[wr_idx]  <= push_qos;
            end

            if (do_load) begin
                bvalid <= 1'b1;
                bid    <= q_id[sel_idx];
                bresp  <= q_resp[sel_idx];
            end else if (bready) begin
                bvalid <= 1'b0;
            end

            case ({do_push, do_load})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_bresp_scheduler.sv
// tb/tb_axi4_bresp_scheduler.sv - directed self-checking bench for axi4_bresp_scheduler
module tb_axi4_bresp_scheduler;
    localparam int IDW   = 4;
    localparam int DEPTH = 8;
    localparam int QW    = 4;
    localparam int CW    = $clog2(DEPTH + 1);

    logic           aclk;
    logic           aresetn;
    logic [1:0]     resp_mode;
    logic [1:0]     qos_mode;
    logic           push_valid;
    logic           push_ready;
    logic [IDW-1:0] push_id;
    logic [1:0]     push_resp;
    logic [QW-1:0]  push_qos;
    logic           bvalid;
    logic           bready;
    logic [IDW-1:0] bid;
    logic [1:0]     bresp;
    logic [CW-1:0]  occupancy;

    int checks;
    int failures;
    int exp_id[$];
    int exp_resp[$];

    axi4_bresp_scheduler #(.ID_WIDTH(IDW), .DEPTH(DEPTH), .QOS_WIDTH(QW)) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .resp_mode  (resp_mode),
        .qos_mode   (qos_mode),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .push_id    (push_id),
        .push_resp  (push_resp),
        .push_qos   (push_qos),
        .bvalid     (bvalid),
        .bready     (bready),
        .bid        (bid),
        .bresp      (bresp),
        .occupancy  (occupancy)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic push(input int id, input int resp, input int qos);
        push_valid = 1'b1;
        push_id    = IDW'(id);
        push_resp  = 2'(resp);
        push_qos   = QW'(qos);
        step();
        push_valid = 1'b0;
    endtask

    task automatic expect_b(input int id, input int resp);
        exp_id.push_back(id);
        exp_resp.push_back(resp);
    endtask

    // Holds bready high and compares each presented response against the expected queue.
    task automatic drain(input string tag);
        int budget;
        budget = 0;
        bready = 1'b1;
        while (exp_id.size() > 0 && budget < 64) begin
            if (bvalid) begin
                check({tag, "_bid"}, 32'(bid), 32'(exp_id.pop_front()));
                check({tag, "_bresp"}, 32'(bresp), 32'(exp_resp.pop_front()));
            end
            step();
            budget++;
        end
        check({tag, "_all_issued"}, 32'(exp_id.size()), 32'd0);
        check({tag, "_bvalid_idle"}, 32'(bvalid), 32'd0);
        check({tag, "_occ_empty"}, 32'(occupancy), 32'd0);
        exp_id.delete();
        exp_resp.delete();
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        aresetn    = 1'b0;
        resp_mode  = 2'b00;
        qos_mode   = 2'b00;
        push_valid = 1'b0;
        push_id    = '0;
        push_resp  = '0;
        push_qos   = '0;
        bready     = 1'b0;

        step();
        step();
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_bid", 32'(bid), 32'd0);
        check("rst_bresp", 32'(bresp), 32'd0);
        check("rst_occ", 32'(occupancy), 32'd0);
        check("rst_push_ready", 32'(push_ready), 32'd1);
        aresetn = 1'b1;

        // In-order issue and one-cycle push-to-bvalid latency
        bready = 1'b1;
        push_valid = 1'b1; push_id = 4'd3; push_resp = 2'd0; push_qos = '0;
        step();
        check("io_lat_bvalid0", 32'(bvalid), 32'd0);
        check("io_lat_occ1", 32'(occupancy), 32'd1);
        push_id = 4'd1; push_resp = 2'd2;
        step();
        check("io_b0_valid", 32'(bvalid), 32'd1);
        check("io_b0_bid", 32'(bid), 32'd3);
        check("io_b0_bresp", 32'(bresp), 32'd0);
        push_id = 4'd2; push_resp = 2'd0;
        step();
        check("io_b1_bid", 32'(bid), 32'd1);
        check("io_b1_bresp", 32'(bresp), 32'd2);
        check("io_b1_occ", 32'(occupancy), 32'd1);
        push_valid = 1'b0;
        step();
        check("io_b2_bid", 32'(bid), 32'd2);
        check("io_b2_bresp", 32'(bresp), 32'd0);
        check("io_b2_occ", 32'(occupancy), 32'd0);
        step();
        check("io_idle", 32'(bvalid), 32'd0);

        // Write OOO without QoS: lowest eligible ID, same-ID order kept; a filler occupies the output first
        bready = 1'b0; resp_mode = 2'b11; qos_mode = 2'b00;
        push(9, 0, 0); push(5, 1, 0); push(2, 0, 0); push(5, 3, 0); push(1, 2, 0);
        check("ooo_occ", 32'(occupancy), 32'd4);
        step(); step();
        check("ooo_stall_bvalid", 32'(bvalid), 32'd1);
        check("ooo_stall_bid", 32'(bid), 32'd9);
        expect_b(9, 0); expect_b(1, 2); expect_b(2, 0); expect_b(5, 1); expect_b(5, 3);
        drain("ooo");

        // Write OOO with QoS: highest qos among eligible, tie to lowest ID
        bready = 1'b0; resp_mode = 2'b10; qos_mode = 2'b11;
        push(0, 0, 0); push(4, 0, 2); push(7, 1, 9); push(7, 2, 15); push(1, 3, 9);
        expect_b(0, 0); expect_b(1, 3); expect_b(7, 1); expect_b(7, 2); expect_b(4, 0);
        drain("qos");

        // Read-only OOO/QoS modes leave write responses in age order
        bready = 1'b0; resp_mode = 2'b01; qos_mode = 2'b10;
        push(0, 0, 0); push(6, 1, 1); push(2, 2, 15);
        expect_b(0, 0); expect_b(6, 1); expect_b(2, 2);
        drain("rdonly");

        // Full queue under backpressure
        bready = 1'b0; resp_mode = 2'b00; qos_mode = 2'b00;
        push_valid = 1'b1; push_qos = '0;
        for (int k = 0; k < 10; k++) begin
            push_id   = IDW'(k);
            push_resp = 2'(k % 4);
            step();
        end
        push_valid = 1'b0;
        check("full_occ", 32'(occupancy), 32'd8);
        check("full_push_ready", 32'(push_ready), 32'd0);
        check("full_bvalid", 32'(bvalid), 32'd1);
        step(); step();
        check("full_bid_stable", 32'(bid), 32'd0);
        check("full_occ_stable", 32'(occupancy), 32'd8);
        bready = 1'b1;
        step();
        check("full_drain_occ7", 32'(occupancy), 32'd7);
        check("full_drain_ready", 32'(push_ready), 32'd1);
        for (int k = 1; k <= 8; k++) expect_b(k, k % 4);
        drain("full");

        // Simultaneous push and load keeps occupancy; new entry waits behind the queue
        bready = 1'b0;
        push(10, 0, 0); push(11, 1, 0); push(12, 2, 0); push(13, 3, 0);
        check("pp_pre_occ", 32'(occupancy), 32'd3);
        check("pp_pre_bid", 32'(bid), 32'd10);
        bready = 1'b1;
        push(14, 0, 0);
        check("pp_occ", 32'(occupancy), 32'd3);
        check("pp_bid", 32'(bid), 32'd11);
        expect_b(11, 1); expect_b(12, 2); expect_b(13, 3); expect_b(14, 0);
        drain("pp");

        // Asynchronous reset mid-operation discards everything
        bready = 1'b0;
        for (int k = 1; k <= 6; k++) push(k, 1, 0);
        check("mr_pre_occ", 32'(occupancy), 32'd5);
        check("mr_pre_bvalid", 32'(bvalid), 32'd1);
        #2;
        aresetn = 1'b0;
        #1;
        check("mr_bvalid", 32'(bvalid), 32'd0);
        check("mr_occ", 32'(occupancy), 32'd0);
        check("mr_bid", 32'(bid), 32'd0);
        check("mr_push_ready", 32'(push_ready), 32'd1);
        step();
        aresetn = 1'b1;
        bready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("mr_no_stale", 32'(bvalid), 32'd0);
        end
        push(11, 1, 0);
        expect_b(11, 1);
        drain("mr_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
